// File: rtl/password_lock_fsm.sv
// Multi-digit code lock: compares each strobed digit against the key, counts failed
// attempts and enforces a timed lockout. All outputs are registered.
module password_lock_fsm #(
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                                            clk100m,
  input  logic                                            rst,
  input  logic [DIGIT_W-1:0]                              digit_in,
  input  logic                                            digit_valid,
  input  logic [DIGIT_W*NUM_DIGITS-1:0]                   key,
  input  logic                                            clear,
  input  logic                                            relock,
  output logic                                            ok,
  output logic                                            lockout,
  output logic                                            fail_pulse,
  output logic [$clog2(MAX_FAILS+1)-1:0]                  fail_cnt,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx
);

  localparam int unsigned FC_W   = $clog2(MAX_FAILS + 1);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int unsigned IDLE_LAST  = TIMEOUT_EN ? (TIMEOUT_CYCLES - 1) : 0;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FC_W-1:0]   FAIL_MAX  = FC_W'(MAX_FAILS);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_END  = IDLE_W'(IDLE_LAST);

  typedef enum logic [1:0] {
    S_ENTRY,
    S_VERDICT,
    S_UNLOCKED,
    S_LOCKOUT
  } state_t;

  state_t              r_state,      w_state_next;
  logic [IDX_W-1:0]    r_idx,        w_idx_next;
  logic                r_mismatch,   w_mismatch_next;
  logic [FC_W-1:0]     r_fail_cnt,   w_fail_cnt_next;
  logic [IDLE_W-1:0]   r_idle,       w_idle_next;
  logic [LOCK_W-1:0]   r_lock_tmr,   w_lock_tmr_next;
  logic                r_fail_pulse, w_fail_pulse_next;
  logic                r_ok;
  logic                r_lockout;
  logic [FC_W-1:0]     w_fail_inc;

  logic [DIGIT_W-1:0]  w_key_digit [NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_key
    assign w_key_digit[gi] = key[gi*DIGIT_W +: DIGIT_W];
  end

  // Saturating increment so the counter can never wrap past MAX_FAILS.
  assign w_fail_inc = (r_fail_cnt == FAIL_MAX) ? r_fail_cnt : r_fail_cnt + FC_W'(1);

  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_mismatch_next   = r_mismatch;
    w_fail_cnt_next   = r_fail_cnt;
    w_idle_next       = r_idle;
    w_lock_tmr_next   = r_lock_tmr;
    w_fail_pulse_next = 1'b0;

    case (r_state)
      S_ENTRY: begin
        if (clear) begin
          w_idx_next      = '0;
          w_mismatch_next = 1'b0;
          w_idle_next     = '0;
        end else if (digit_valid) begin
          w_mismatch_next = r_mismatch | (digit_in != w_key_digit[r_idx]);
          w_idle_next     = '0;
          if (r_idx == LAST_IDX) begin
            w_idx_next   = '0;
            w_state_next = S_VERDICT;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end else if (TIMEOUT_EN && (r_idx != '0)) begin
          if (r_idle == IDLE_END) begin
            w_idx_next      = '0;
            w_mismatch_next = 1'b0;
            w_idle_next     = '0;
          end else begin
            w_idle_next = r_idle + IDLE_W'(1);
          end
        end
      end

      S_VERDICT: begin
        w_mismatch_next = 1'b0;
        if (!r_mismatch) begin
          w_state_next    = S_UNLOCKED;
          w_fail_cnt_next = '0;
        end else begin
          w_fail_pulse_next = 1'b1;
          w_fail_cnt_next   = w_fail_inc;
          if (w_fail_inc == FAIL_MAX) begin
            w_state_next    = S_LOCKOUT;
            w_lock_tmr_next = LOCK_LOAD;
          end else begin
            w_state_next = S_ENTRY;
          end
        end
      end

      S_UNLOCKED: begin
        if (relock) begin
          w_state_next = S_ENTRY;
        end
      end

      S_LOCKOUT: begin
        if (r_lock_tmr == '0) begin
          w_state_next    = S_ENTRY;
          w_fail_cnt_next = '0;
        end else begin
          w_lock_tmr_next = r_lock_tmr - LOCK_W'(1);
        end
      end

      default: begin
        w_state_next = S_ENTRY;
      end
    endcase
  end

  // ok/lockout are derived from the next state so they track the state register exactly.
  always_ff @(posedge clk100m or negedge rst) begin
    if (!rst) begin
      r_state      <= S_ENTRY;
      r_idx        <= '0;
      r_mismatch   <= 1'b0;
      r_fail_cnt   <= '0;
      r_idle       <= '0;
      r_lock_tmr   <= '0;
      r_fail_pulse <= 1'b0;
      r_ok         <= 1'b0;
      r_lockout    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_mismatch   <= w_mismatch_next;
      r_fail_cnt   <= w_fail_cnt_next;
      r_idle       <= w_idle_next;
      r_lock_tmr   <= w_lock_tmr_next;
      r_fail_pulse <= w_fail_pulse_next;
      r_ok         <= (w_state_next == S_UNLOCKED);
      r_lockout    <= (w_state_next == S_LOCKOUT);
    end
  end

  assign ok         = r_ok;
  assign lockout    = r_lockout;
  assign fail_pulse = r_fail_pulse;
  assign fail_cnt   = r_fail_cnt;
  assign digit_idx  = r_idx;

endmodule

// File: doc/password_lock_fsm.md
Name: password_lock_fsm

Overview:
- Parametrised successor to the single-nibble password check on the CPU top.
- Accepts a multi-digit code one digit per strobe and compares each digit on the fly against a key vector.
- Asserts `ok` on a full match. Counts failed attempts and enforces a timed lockout after MAX_FAILS failures.
- Sits between the board switch/button debouncers and the CPU enable/display logic, in the clk100m domain.

Parameters:
- DIGIT_W, 4, bits per digit.
- NUM_DIGITS, 4, digits per code (>=1).
- MAX_FAILS, 3, consecutive failed attempts before lockout (>=1).
- LOCKOUT_CYCLES, 100000000, lockout duration in clk100m cycles (>=1).
- TIMEOUT_CYCLES, 0, idle cycles mid-entry before silent abort; 0 disables.

Ports:
- clk100m  in  1  system clock, rising-edge.
- rst  in  1  asynchronous active-low reset.
- digit_in  in  DIGIT_W  digit value, sampled when digit_valid=1.
- digit_valid  in  1  one-cycle digit strobe.
- key  in  DIGIT_W*NUM_DIGITS  stored code; digit i = key[i*DIGIT_W +: DIGIT_W]; digit 0 entered first.
- clear  in  1  abort current entry (not counted as failure).
- relock  in  1  leave UNLOCKED.
- ok  out  1  high while UNLOCKED.
- lockout  out  1  high while LOCKOUT.
- fail_pulse  out  1  one-cycle pulse per failed attempt.
- fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failures.
- digit_idx  out  max($clog2(NUM_DIGITS),1)  next digit position expected.

Behaviour:
- Reset (rst=0, async): state=ENTRY; idx, mismatch flag, fail_cnt, timers cleared; ok=lockout=fail_pulse=0. All outputs are registered.
- States: ENTRY, VERDICT, UNLOCKED, LOCKOUT.
- ENTRY:
  - On digit_valid, mismatch |= (digit_in != key digit[idx]), using key as sampled that cycle.
  - If idx < NUM_DIGITS-1: idx++.
  - Else: idx=0 and go to VERDICT.
  - clear=1: idx=0, mismatch=0, stay in ENTRY, no failure counted. clear has priority over a same-cycle digit_valid, which is dropped.
  - Idle timer: counts cycles with idx>0 and no digit_valid; reloads on every digit.
  - If TIMEOUT_CYCLES>0 and the timer reaches TIMEOUT_CYCLES, the entry aborts as if clear=1.
- VERDICT (exactly one cycle; digit_valid/clear/relock ignored; mismatch is cleared on exit):
  - mismatch=0: go to UNLOCKED, fail_cnt=0.
  - mismatch=1: fail_pulse=1 for this cycle, fail_cnt++.
    - If the new fail_cnt == MAX_FAILS: go to LOCKOUT, timer=LOCKOUT_CYCLES-1.
    - Else: go to ENTRY.
- Latency: the final digit is sampled on edge k; ok rises or fail_pulse asserts after edge k+1.
- UNLOCKED: ok=1; digit_valid and clear ignored. relock=1 → ENTRY next edge, ok=0.
- LOCKOUT: lockout=1; all inputs ignored. Timer decrements each cycle. When timer==0: next edge → ENTRY, lockout=0, fail_cnt=0. Lockout lasts exactly LOCKOUT_CYCLES cycles.
- fail_cnt saturates at MAX_FAILS and never wraps.
- A successful unlock resets fail_cnt. clear and timeout do not change fail_cnt.
- NUM_DIGITS=1: every digit_valid goes directly to VERDICT.
- Reset asserted in any state returns immediately to the reset values. No partial entry survives.

Test Plan (DIGIT_W=4, NUM_DIGITS=4, MAX_FAILS=3, LOCKOUT_CYCLES=8, TIMEOUT_CYCLES=16, key=16'h4321):
- Strobe digits 1,2,3,4 on consecutive cycles → ok=1 after the edge following the 4th sample; fail_cnt=0. Then relock pulse → ok=0, digit_idx=0.
- Strobe 1,2,3,5 → single-cycle fail_pulse, fail_cnt=1, ok stays 0. Then 1,2,3,4 → ok=1, fail_cnt=0.
- Three wrong codes (1,1,1,1 ×3) → fail_cnt=3, lockout=1 for exactly 8 cycles, and strobing 1,2,3,4 during lockout has no effect. After lockout: lockout=0, fail_cnt=0, and 1,2,3,4 then gives ok=1.
- Strobe 1,2, then clear together with a digit_valid of 3 → digit_idx=0, no fail_pulse. Then 1,2,3,4 → ok=1.
- Strobe 1 then idle 16 cycles → digit_idx returns to 0, fail_cnt unchanged. Idle with digit_idx=0 for 100 cycles → no change.
- Strobe 1,2,3, pulse rst low mid-entry → all outputs 0 asynchronously. After release, 4 alone does not unlock and digit_idx=1.
